// File: rtl/region_rgb_mux.sv
// Region-based RGB multiplexer for a raster video pipeline.
// A set of programmable rectangles selects per-pixel source colours with
// fixed priority (lowest index wins). A two-stage pipeline produces a
// registered output pixel. A frame-based blink can invert the region
// that is being edited.
module region_rgb_mux #(
  parameter int N_REG        = 8,
  parameter int RGB_W        = 12,
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     video_on,
  input  logic [COORD_W-1:0]       pix_x,
  input  logic [COORD_W-1:0]       pix_y,
  input  logic                     frame_tick,
  input  logic [N_REG*RGB_W-1:0]   rgb_src,
  input  logic [RGB_W-1:0]         rgb_bg,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_idx,
  input  logic                     cfg_en,
  input  logic [COORD_W-1:0]       cfg_x0,
  input  logic [COORD_W-1:0]       cfg_x1,
  input  logic [COORD_W-1:0]       cfg_y0,
  input  logic [COORD_W-1:0]       cfg_y1,
  input  logic                     edit_en,
  input  logic [3:0]               edit_idx,
  output logic [RGB_W-1:0]         rgb_screen,
  output logic [N_REG-1:0]         hit_flags,
  output logic                     blink_phase
);

  logic [N_REG-1:0] hit;
  logic [N_REG-1:0] hit_s1_reg;
  logic             von_s1_reg;
  logic [7:0]       blink_cnt_reg;

  logic [N_REG-1:0] win_onehot;
  logic [3:0]       win_idx;
  logic             win_any;
  logic [RGB_W-1:0] win_src;
  logic             edit_match;
  logic [RGB_W-1:0] pix_next;
  logic [N_REG-1:0] flags_next;

  // Per-region configuration registers and rectangle hit test.
  // A write with cfg_idx outside 0..N_REG-1 matches no region and is dropped.
  for (genvar gi = 0; gi < N_REG; gi++) begin : g_region
    logic               en_reg;
    logic [COORD_W-1:0] x0_reg, x1_reg, y0_reg, y1_reg;

    // Region register file: written by the configuration strobe.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en_reg <= 1'b0;
        x0_reg <= '0;
        x1_reg <= '0;
        y0_reg <= '0;
        y1_reg <= '0;
      end else if (cfg_we && cfg_idx == 4'(gi)) begin
        en_reg <= cfg_en;
        x0_reg <= cfg_x0;
        x1_reg <= cfg_x1;
        y0_reg <= cfg_y0;
        y1_reg <= cfg_y1;
      end
    end

    // Inverted bounds (x0>x1 or y0>y1) can never satisfy both compares.
    assign hit[gi] = en_reg &&
                     (x0_reg <= pix_x) && (pix_x <= x1_reg) &&
                     (y0_reg <= pix_y) && (pix_y <= y1_reg);
  end

  // Stage 1: capture hit vector and the matching video_on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_s1_reg <= '0;
      von_s1_reg <= 1'b0;
    end else begin
      hit_s1_reg <= hit;
      von_s1_reg <= video_on;
    end
  end

  // Winner select (lowest index wins) and stage-2 next values.
  always_comb begin
    win_onehot = hit_s1_reg & (~hit_s1_reg + 1'b1);
    win_any    = |hit_s1_reg;
    win_idx    = 4'd0;
    win_src    = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (hit_s1_reg[i]) begin
        win_idx = 4'(i);
        win_src = rgb_src[i*RGB_W +: RGB_W];
      end
    end
    edit_match = edit_en && ({1'b0, edit_idx} < 5'(N_REG)) &&
                 (edit_idx == win_idx) && !blink_phase;
    if (!von_s1_reg)
      pix_next = '0;
    else if (win_any)
      pix_next = edit_match ? ~win_src : win_src;
    else
      pix_next = rgb_bg;
    // Set wins over the frame clear when both happen on the same edge.
    flags_next = (frame_tick ? '0 : hit_flags) |
                 (von_s1_reg ? win_onehot : '0);
  end

  // Stage 2: registered output pixel and sticky per-frame hit flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_screen <= '0;
      hit_flags  <= '0;
    end else begin
      rgb_screen <= pix_next;
      hit_flags  <= flags_next;
    end
  end

  // Blink counter: counts frames, toggles the phase on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_reg <= 8'd0;
      blink_phase   <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_reg == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= 8'd0;
        blink_phase   <= ~blink_phase;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_region_rgb_mux.sv
// Self-checking bench for region_rgb_mux: table-driven pixel vectors feed a
// scoreboard queue that is checked two cycles later, plus hand sequences for
// blink, frame-flag and reset corner cases.
module tb_region_rgb_mux;
  localparam int N_REG = 8;
  localparam int RGB_W = 12;
  localparam int CW    = 10;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   video_on;
  logic [CW-1:0]          pix_x, pix_y;
  logic                   frame_tick;
  logic [N_REG*RGB_W-1:0] rgb_src;
  logic [RGB_W-1:0]       rgb_bg;
  logic                   cfg_we;
  logic [3:0]             cfg_idx;
  logic                   cfg_en;
  logic [CW-1:0]          cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  logic                   edit_en;
  logic [3:0]             edit_idx;
  logic [RGB_W-1:0]       rgb_screen;
  logic [N_REG-1:0]       hit_flags;
  logic                   blink_phase;

  region_rgb_mux #(.N_REG(N_REG), .RGB_W(RGB_W), .COORD_W(CW), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(rst_n), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .rgb_src(rgb_src), .rgb_bg(rgb_bg),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .edit_en(edit_en), .edit_idx(edit_idx),
    .rgb_screen(rgb_screen), .hit_flags(hit_flags), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic             von;
    logic [RGB_W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [RGB_W-1:0] exp;
    int               tag;
  } sb_t;

  sb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;
  logic drv_valid = 1'b0;
  logic vld1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Scoreboard monitor: a pixel driven in cycle N is checked just after edge N+2.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      vld1 = 1'b0;
    end else begin
      if (vld1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          check($sformatf("pixel_%0d", e.tag), 32'(rgb_screen), 32'(e.exp));
        end
      end
      vld1 = drv_valid;
    end
  end

  // All tasks set inputs at a falling edge and return at the next one.
  task automatic drive(input logic [CW-1:0] x, input logic [CW-1:0] y,
                       input logic von, input logic [RGB_W-1:0] exp);
    sb_t e;
    pix_x = x; pix_y = y; video_on = von; drv_valid = 1'b1;
    e.exp = exp; e.tag = tag_cnt++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv_valid = 1'b0; video_on = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [3:0] idx, input logic en, input logic [CW-1:0] x0,
                     input logic [CW-1:0] x1, input logic [CW-1:0] y0, input logic [CW-1:0] y1);
    drv_valid = 1'b0; video_on = 1'b0;
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en;
    cfg_x0 = x0; cfg_x1 = x1; cfg_y0 = y0; cfg_y1 = y1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    drv_valid = 1'b0; video_on = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic [RGB_W-1:0] v);
    rgb_src[i*RGB_W +: RGB_W] = v;
  endtask

  vec_t tbl[$];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; video_on = 1'b0; pix_x = '0; pix_y = '0; frame_tick = 1'b0;
    rgb_src = '0; rgb_bg = 12'h555; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0; edit_en = 1'b0; edit_idx = '0;
    for (int i = 0; i < N_REG; i++) set_src(i, 12'h123);
    set_src(0, 12'hF00); set_src(1, 12'h0A0); set_src(3, 12'h00F);

    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(rgb_screen), 32'h0);
    check("reset_flags", 32'(hit_flags), 32'h0);
    check("reset_phase", 32'(blink_phase), 32'h1);
    rst_n = 1'b1;

    // Regions all disabled out of reset: background only.
    drive(10'd200, 10'd70, 1'b1, 12'h555);
    cfg(4'd0, 1'b1, 10'd192, 10'd255, 10'd64, 10'd127);
    cfg(4'd3, 1'b1, 10'd250, 10'd400, 10'd150, 10'd250);
    cfg(4'd1, 1'b1, 10'd10, 10'd20, 10'd10, 10'd20);

    tbl = '{
      '{x:10'd200, y:10'd70,  von:1'b1, exp:12'hF00},
      '{x:10'd192, y:10'd64,  von:1'b1, exp:12'hF00},
      '{x:10'd255, y:10'd127, von:1'b1, exp:12'hF00},
      '{x:10'd256, y:10'd127, von:1'b1, exp:12'h555},
      '{x:10'd255, y:10'd128, von:1'b1, exp:12'h555},
      '{x:10'd191, y:10'd64,  von:1'b1, exp:12'h555},
      '{x:10'd300, y:10'd200, von:1'b1, exp:12'h00F},
      '{x:10'd15,  y:10'd15,  von:1'b1, exp:12'h0A0},
      '{x:10'd200, y:10'd70,  von:1'b0, exp:12'h000},
      '{x:10'd500, y:10'd500, von:1'b1, exp:12'h555}
    };
    for (int k = 0; k < tbl.size(); k++) drive(tbl[k].x, tbl[k].y, tbl[k].von, tbl[k].exp);
    idle(3);
    check("flags_after_table", 32'(hit_flags), 32'h0B);

    // Inverted rectangle never hits; out-of-range index write is ignored.
    cfg(4'd2, 1'b1, 10'd100, 10'd50, 10'd0, 10'd1000);
    drive(10'd75, 10'd10, 1'b1, 12'h555);
    cfg(4'd9, 1'b1, 10'd0, 10'd1023, 10'd0, 10'd1023);
    drive(10'd600, 10'd600, 1'b1, 12'h555);

    // Overlap priority, then disable region 0 and see region 3 take over.
    idle(3);
    set_src(0, 12'h0F0);
    cfg(4'd0, 1'b1, 10'd280, 10'd320, 10'd180, 10'd220);
    drive(10'd300, 10'd200, 1'b1, 12'h0F0);
    cfg(4'd0, 1'b0, 10'd280, 10'd320, 10'd180, 10'd220);
    drive(10'd300, 10'd200, 1'b1, 12'h00F);
    idle(3);
    check("flags_before_tick", 32'(hit_flags), 32'h0B);
    tick();
    check("flags_cleared", 32'(hit_flags), 32'h0);
    check("phase_after_1_tick", 32'(blink_phase), 32'h1);

    // Frame tick coinciding with the stage-2 hit of region 1: flag survives.
    drive(10'd15, 10'd15, 1'b1, 12'h0A0);
    tick();
    idle(2);
    check("flags_tick_and_set", 32'(hit_flags), 32'h02);
    check("phase_after_2_ticks", 32'(blink_phase), 32'h0);

    // Blinking edit region.
    set_src(0, 12'hF00);
    cfg(4'd0, 1'b1, 10'd192, 10'd255, 10'd64, 10'd127);
    edit_en = 1'b1; edit_idx = 4'd0;
    drive(10'd200, 10'd70, 1'b1, 12'h0FF);
    idle(3);
    tick(); tick();
    check("phase_after_4_ticks", 32'(blink_phase), 32'h1);
    drive(10'd200, 10'd70, 1'b1, 12'hF00);
    idle(3);
    tick(); tick();
    check("phase_after_6_ticks", 32'(blink_phase), 32'h0);
    edit_idx = 4'd8;
    drive(10'd200, 10'd70, 1'b1, 12'hF00);
    idle(3);
    edit_idx = 4'd3;
    drive(10'd300, 10'd200, 1'b1, 12'hFF0);
    drive(10'd200, 10'd70, 1'b1, 12'hF00);
    idle(3);
    edit_en = 1'b0;

    // Reset during active video discards the pipeline and all regions.
    drive(10'd200, 10'd70, 1'b1, 12'hF00);
    drive(10'd200, 10'd70, 1'b1, 12'hF00);
    drive(10'd200, 10'd70, 1'b1, 12'hF00);
    drv_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midreset_rgb", 32'(rgb_screen), 32'h0);
    check("midreset_flags", 32'(hit_flags), 32'h0);
    check("midreset_phase", 32'(blink_phase), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(10'd200, 10'd70, 1'b1, 12'h555);
    drive(10'd15, 10'd15, 1'b1, 12'h555);
    idle(4);
    check("flags_after_reset", 32'(hit_flags), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
